// File: rtl/dataflow_pkg.sv
// Pipeline register layouts and stage state types for the datapath.
package dataflow_pkg;
  import extensions_pkg::*;

  localparam int ByteLanes = DataSize / 8;
  localparam int OffW      = $clog2(ByteLanes);

  typedef enum logic {Idle, Request} memory_stage_state_t;

  typedef struct packed {
    logic [DataSize-1:0]  pc_plus_4;
    logic [4:0]           rd;
    logic [DataSize-1:0]  csr_read_data;
    logic [DataSize-1:0]  alu_y;
    logic [DataSize-1:0]  write_data;
    logic                 mem_read_enable;
    logic                 mem_write_enable;
    logic [ByteLanes-1:0] mem_byte_en;
    logic [1:0]           wr_reg_src;
    logic                 wr_reg_en;
  } ex_mem_t;

  typedef struct packed {
    logic [DataSize-1:0] pc_plus_4;
    logic [4:0]          rd;
    logic [DataSize-1:0] csr_read_data;
    logic [DataSize-1:0] alu_y;
    logic [DataSize-1:0] read_data;
    logic [1:0]          wr_reg_src;
    logic                wr_reg_en;
  } mem_wb_t;
endpackage

// File: rtl/extensions_pkg.sv
// Build-wide datapath width options shared by the pipeline stages.
package extensions_pkg;
  localparam int DataSize = 32;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a byte address and the word-wide data bus.
// Lanes pushed past the top of the word are discarded, not wrapped.
module mem_lane_align
  import extensions_pkg::*;
  import dataflow_pkg::*;
(
  input  logic [DataSize-1:0]  alu_y_i,
  input  logic [ByteLanes-1:0] byte_en_i,
  input  logic [DataSize-1:0]  wr_data_i,
  input  logic [DataSize-1:0]  rd_data_i,
  output logic [DataSize-1:0]  addr_o,
  output logic [ByteLanes-1:0] byte_en_o,
  output logic [DataSize-1:0]  wr_data_o,
  output logic [DataSize-1:0]  rd_data_o
);
  logic [OffW-1:0] off;
  logic [OffW+2:0] bit_off;

  assign off     = alu_y_i[OffW-1:0];
  assign bit_off = {off, 3'b000};

  assign addr_o    = {alu_y_i[DataSize-1:OffW], {OffW{1'b0}}};
  assign byte_en_o = byte_en_i << off;
  assign wr_data_o = wr_data_i << bit_off;
  assign rd_data_o = rd_data_i >> bit_off;
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store and
// stalls upstream until the memory acknowledges it.
//
//   state   | meaning
//   Idle    | no request outstanding; non-access instructions pass in 1 cycle
//   Request | request registers drive the memory until mem_ack_i
module memory_stage
  import extensions_pkg::*;
  import dataflow_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  ex_mem_t              ex_mem_i,
  input  logic                 ex_mem_valid_i,
  output logic                 stall_o,
  output logic                 mem_rd_en_o,
  output logic                 mem_wr_en_o,
  output logic [DataSize-1:0]  mem_addr_o,
  output logic [ByteLanes-1:0] mem_byte_en_o,
  output logic [DataSize-1:0]  mem_wr_data_o,
  input  logic [DataSize-1:0]  mem_rd_data_i,
  input  logic                 mem_ack_i,
  output mem_wb_t              mem_wb_o,
  output logic                 mem_wb_valid_o
);
  memory_stage_state_t  state_q;
  logic                 rd_q, wr_q;
  logic [DataSize-1:0]  addr_q, wr_data_q;
  logic [ByteLanes-1:0] be_q;
  mem_wb_t              req_wb_q, mem_wb_q;
  logic                 mem_wb_valid_q;

  logic                 access, is_rd, is_wr;
  mem_wb_t              pass_d;
  logic [DataSize-1:0]  align_alu_y, align_addr, align_wr_data, align_rd_data;
  logic [ByteLanes-1:0] align_be;

  // A write wins over a simultaneous read.
  assign is_wr  = ex_mem_i.mem_write_enable;
  assign is_rd  = ex_mem_i.mem_read_enable & ~ex_mem_i.mem_write_enable;
  assign access = ex_mem_valid_i & (ex_mem_i.mem_read_enable | ex_mem_i.mem_write_enable);

  always_comb begin
    pass_d               = '0;
    pass_d.pc_plus_4     = ex_mem_i.pc_plus_4;
    pass_d.rd            = ex_mem_i.rd;
    pass_d.csr_read_data = ex_mem_i.csr_read_data;
    pass_d.alu_y         = ex_mem_i.alu_y;
    pass_d.wr_reg_src    = ex_mem_i.wr_reg_src;
    pass_d.wr_reg_en     = ex_mem_i.wr_reg_en;
  end

  // One aligner serves both phases: Idle shapes the outgoing request from
  // the incoming instruction, Request shifts returning data by the latched offset.
  assign align_alu_y = (state_q == Request) ? req_wb_q.alu_y : ex_mem_i.alu_y;

  mem_lane_align u_align (
    .alu_y_i   (align_alu_y),
    .byte_en_i (ex_mem_i.mem_byte_en),
    .wr_data_i (ex_mem_i.write_data),
    .rd_data_i (mem_rd_data_i),
    .addr_o    (align_addr),
    .byte_en_o (align_be),
    .wr_data_o (align_wr_data),
    .rd_data_o (align_rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= Idle;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wr_data_q      <= '0;
      req_wb_q       <= '0;
      mem_wb_q       <= '0;
      mem_wb_valid_q <= 1'b0;
    end else begin
      mem_wb_valid_q     <= 1'b0;
      mem_wb_q.wr_reg_en <= 1'b0;
      case (state_q)
        Idle: begin
          if (access) begin
            state_q   <= Request;
            rd_q      <= is_rd;
            wr_q      <= is_wr;
            addr_q    <= align_addr;
            be_q      <= align_be;
            wr_data_q <= align_wr_data;
            req_wb_q  <= pass_d;
          end else if (ex_mem_valid_i) begin
            mem_wb_q       <= pass_d;
            mem_wb_valid_q <= 1'b1;
          end
        end
        Request: begin
          if (mem_ack_i) begin
            state_q            <= Idle;
            mem_wb_q           <= req_wb_q;
            mem_wb_q.read_data <= rd_q ? align_rd_data : '0;
            mem_wb_valid_q     <= 1'b1;
            rd_q               <= 1'b0;
            wr_q               <= 1'b0;
            addr_q             <= '0;
            be_q               <= '0;
            wr_data_q          <= '0;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Request registers are zero in Idle; the reset gate covers the reset cycle itself.
  assign stall_o = ~reset & (((state_q == Idle) & access) |
                             ((state_q == Request) & ~mem_ack_i));
  assign mem_rd_en_o    = ~reset & rd_q;
  assign mem_wr_en_o    = ~reset & wr_q;
  assign mem_addr_o     = reset ? '0 : addr_q;
  assign mem_byte_en_o  = reset ? '0 : be_q;
  assign mem_wr_data_o  = reset ? '0 : wr_data_q;
  assign mem_wb_o       = mem_wb_q;
  assign mem_wb_valid_o = mem_wb_valid_q;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected requests and MEM/WB results are
// queued at issue time and compared when the DUT presents them.
module tb_memory_stage;
  import extensions_pkg::*;
  import dataflow_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  ex_mem_t     ex_mem_i = '0;
  logic        ex_mem_valid_i = 1'b0;
  logic        stall_o, mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_wr_data_o;
  logic [3:0]  mem_byte_en_o;
  logic [31:0] mem_rd_data_i = '0;
  logic        mem_ack_i;
  mem_wb_t     mem_wb_o;
  logic        mem_wb_valid_o;

  logic        resp_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic        resp_en = 1'b1;
  logic        started = 1'b0;
  int          ack_dly = 0;
  int          req_cyc = 0;
  logic [31:0] rd_word = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  req_t        req_q[$];
  mem_wb_t     wb_q[$];

  assign mem_ack_i = resp_ack | force_ack;

  memory_stage dut (
    .clock          (clock),
    .reset          (reset),
    .ex_mem_i       (ex_mem_i),
    .ex_mem_valid_i (ex_mem_valid_i),
    .stall_o        (stall_o),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_ack_i      (mem_ack_i),
    .mem_wb_o       (mem_wb_o),
    .mem_wb_valid_o (mem_wb_valid_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic req_t model_req(input ex_mem_t e);
    req_t r;
    int   off;
    off    = int'(e.alu_y[1:0]);
    r.wr   = e.mem_write_enable;
    r.rd   = e.mem_read_enable & ~e.mem_write_enable;
    r.addr = e.alu_y & 32'hFFFF_FFFC;
    r.be   = e.mem_byte_en << off;
    r.wd   = e.write_data << (8 * off);
    return r;
  endfunction

  function automatic mem_wb_t model_wb(input ex_mem_t e, input logic acc, input logic [31:0] rdat);
    mem_wb_t w;
    int      off;
    off             = int'(e.alu_y[1:0]);
    w.pc_plus_4     = e.pc_plus_4;
    w.rd            = e.rd;
    w.csr_read_data = e.csr_read_data;
    w.alu_y         = e.alu_y;
    w.wr_reg_src    = e.wr_reg_src;
    w.wr_reg_en     = e.wr_reg_en;
    w.read_data     = (acc && e.mem_read_enable && !e.mem_write_enable) ? (rdat >> (8 * off)) : 32'h0;
    return w;
  endfunction

  function automatic ex_mem_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [3:0] be, input logic r, input logic w);
    ex_mem_t e;
    e.pc_plus_4        = $urandom;
    e.rd               = 5'($urandom_range(1, 31));
    e.csr_read_data    = $urandom;
    e.alu_y            = alu;
    e.write_data       = wd;
    e.mem_read_enable  = r;
    e.mem_write_enable = w;
    e.mem_byte_en      = be;
    e.wr_reg_src       = 2'($urandom_range(0, 3));
    e.wr_reg_en        = 1'b1;
    return e;
  endfunction

  task automatic issue(input ex_mem_t e, input logic v, input int dly, input logic [31:0] rdat);
    int   stalls;
    logic acc;
    acc = v && (e.mem_read_enable || e.mem_write_enable);
    @(negedge clock);
    ex_mem_i       = e;
    ex_mem_valid_i = v;
    ack_dly        = dly;
    rd_word        = rdat;
    if (acc) req_q.push_back(model_req(e));
    if (v) wb_q.push_back(model_wb(e, acc, rdat));
    stalls = 0;
    #1;
    while (stall_o && stalls < 40) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    check("stall_cycles", 256'(stalls), 256'(acc ? dly + 1 : 0));
    @(posedge clock);
    #1 ex_mem_valid_i = 1'b0;
  endtask

  // Memory model: acks after ack_dly request cycles, checks request stability meanwhile.
  always @(negedge clock) begin
    if (!resp_en) begin
      resp_ack = 1'b0;
    end else if (mem_rd_en_o || mem_wr_en_o) begin
      req_t obs;
      obs = '{rd: mem_rd_en_o, wr: mem_wr_en_o, addr: mem_addr_o, be: mem_byte_en_o, wd: mem_wr_data_o};
      req_cyc++;
      if (req_q.size() == 0) check("req_unexpected", 256'(1), 256'(0));
      else check("req", 256'(obs), 256'(req_q[0]));
      if (req_cyc > ack_dly) begin
        resp_ack      = 1'b1;
        mem_rd_data_i = rd_word;
        req_cyc       = 0;
        if (req_q.size() != 0) void'(req_q.pop_front());
      end else begin
        resp_ack      = 1'b0;
        mem_rd_data_i = $urandom;
      end
    end else begin
      resp_ack      = 1'b0;
      req_cyc       = 0;
      mem_rd_data_i = $urandom;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      if (mem_wb_valid_o) begin
        mem_wb_t e;
        if (wb_q.size() == 0) check("wb_unexpected", 256'(1), 256'(0));
        else begin
          e = wb_q.pop_front();
          check("wb", 256'(mem_wb_o), 256'(e));
        end
      end else begin
        check("wb_wren_invalid", 256'(mem_wb_o.wr_reg_en), 256'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ex_mem_t e;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_wb", 256'(mem_wb_o), 256'(0));
    check("rst_wb_valid", 256'(mem_wb_valid_o), 256'(0));
    check("rst_stall", 256'(stall_o), 256'(0));
    check("rst_req", 256'({mem_rd_en_o, mem_wr_en_o, mem_addr_o}), 256'(0));
    reset   = 1'b0;
    started = 1'b1;

    // non-access instruction passes with one-cycle latency
    e = mk(32'h1234, 32'h0, 4'b0000, 1'b0, 1'b0);
    issue(e, 1'b1, 0, 32'h0);
    // byte store to the top lane, ack after three waiting request cycles
    issue(mk(32'h1003, 32'h0000_00AB, 4'b0001, 1'b0, 1'b1), 1'b1, 3, 32'h0);
    // half load from the upper half, immediate ack
    issue(mk(32'h2002, 32'h0, 4'b0011, 1'b1, 1'b0), 1'b1, 0, 32'hBEEF_0000);
    // read+write together behave as a write, read data dropped
    issue(mk(32'h3001, 32'h1122_3344, 4'b1111, 1'b1, 1'b1), 1'b1, 1, 32'hFFFF_FFFF);
    // invalid instruction with read enable is ignored entirely
    issue(mk(32'h7000, 32'h0, 4'b1111, 1'b1, 1'b0), 1'b0, 0, 32'h0);
    #1;
    check("inval_wb_valid", 256'(mem_wb_valid_o), 256'(0));
    check("inval_rd_en", 256'(mem_rd_en_o), 256'(0));
    check("inval_stall", 256'(stall_o), 256'(0));
    // word load and a store whose lanes spill past the word
    issue(mk(32'h4000, 32'h0, 4'b1111, 1'b1, 1'b0), 1'b1, 1, 32'hCAFE_F00D);
    issue(mk(32'h5002, 32'hAABB_CCDD, 4'b1111, 1'b0, 1'b1), 1'b1, 2, 32'h0);

    for (int i = 0; i < 16; i++) begin
      int          kind;
      logic [3:0]  be;
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: be = 4'b0001;
        1: be = 4'b0011;
        default: be = 4'b1111;
      endcase
      issue(mk($urandom, $urandom, be, kind[0], kind[1]), 1'b1, $urandom_range(0, 3), $urandom);
    end

    // reset while a request is outstanding, then a stray ack
    resp_en = 1'b0;
    @(negedge clock);
    ex_mem_i       = mk(32'h6004, 32'h0, 4'b1111, 1'b1, 1'b0);
    ex_mem_valid_i = 1'b1;
    #1 check("rstreq_stall_idle", 256'(stall_o), 256'(1));
    @(negedge clock);
    #1 check("rstreq_rd_en", 256'(mem_rd_en_o), 256'(1));
    reset          = 1'b1;
    ex_mem_valid_i = 1'b0;
    #1;
    check("rstreq_cycle_stall", 256'(stall_o), 256'(0));
    check("rstreq_cycle_req", 256'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_byte_en_o, mem_wr_data_o}), 256'(0));
    @(negedge clock);
    reset     = 1'b0;
    force_ack = 1'b1;
    #1;
    check("rstreq_idle_stall", 256'(stall_o), 256'(0));
    check("rstreq_idle_req", 256'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_byte_en_o, mem_wr_data_o}), 256'(0));
    check("rstreq_idle_wbv", 256'(mem_wb_valid_o), 256'(0));
    @(negedge clock);
    force_ack = 1'b0;
    #1;
    check("rstreq_ack_ignored_wbv", 256'(mem_wb_valid_o), 256'(0));
    check("rstreq_ack_ignored_req", 256'({mem_rd_en_o, mem_wr_en_o}), 256'(0));
    resp_en = 1'b1;

    issue(mk(32'h8001, 32'h0, 4'b0001, 1'b1, 1'b0), 1'b1, 1, 32'h0000_5A00);
    repeat (3) @(negedge clock);
    check("drain_wb", 256'(wb_q.size()), 256'(0));
    check("drain_req", 256'(req_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
